rv_uart_top_lite: RTL and testbench
===================================

# rv_uart_top_lite

Board-level top for the Mini-RISC-V UART platform, reduced to its I/O shell: 8N1 UART receiver and echo transmitter, key-locked data path, 8-digit seven-segment scanner, LED status and a divided clock output. It sits directly under the FPGA pin constraints. It gives the bench a deterministic UART/display/key contract.

## Interface
- CLKS_PER_BIT, 900, clk cycles per UART bit; 9000 ns at a 100 MHz clk.
- SCAN_CYCLES, 1024, clk cycles each seven-segment digit stays enabled.
- KEY_GOLDEN, 96'h3cf3cf3cf3cf_30c30c_bae_3cf, unlocking key value.
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; idle high.
- prog  in  1  program mode: receive only, echo suppressed.
- debug  in  1  selects the debug word on the display.
- debug_input  in  5  debug word select; bits [1:0] used, [4:2] ignored.
- key  in  96  logic-locking key.
- tx  out  1  UART serial output; idle high.
- clk_out  out  1  clk divided by 2; internal name clk_50M.
- sev_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  8  digit enables, active-low, one-hot-low.
- led  out  16  status LEDs.

## Operation
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on rx=0.
  - START re-samples rx at CLKS_PER_BIT/2. If rx=1 it returns to IDLE (glitch); otherwise it goes to DATA.
  - DATA samples 8 bits, LSB first, one every CLKS_PER_BIT.
  - STOP samples the stop bit mid-bit, then returns to IDLE.
- Stop bit 1: byte is valid and rx_valid pulses for 1 cycle. Stop bit 0: byte discarded and led[8] set; led[8] is sticky until reset.
- On a valid byte:
  - rx_word <= {byte, rx_word[31:8]}, so bytes EF,BE,AD,DE give 0xDEADBEEF.
  - led[7:0] <= byte.
  - rx_count (8-bit, wraps 255→0) increments.
- Echo: if prog=0, echo_byte = byte XOR scramble is queued to TX. scramble is the XOR of all 12 bytes of (key XOR KEY_GOLDEN), so scramble=0 for the correct key.
- TX FSM states: IDLE, START, DATA, STOP, each bit CLKS_PER_BIT cycles. TX has a one-byte holding register; a new byte arriving while TX is busy overwrites the pending byte.
- Display value:
  - debug=0: rx_word.
  - debug=1, debug_input[1:0]: 0=key[31:0], 1=key[63:32], 2=key[95:64], 3={24'h0, rx_count}.
- Scanner: a digit index cycles 0..7, advancing every SCAN_CYCLES. an[i]=0 for the active digit. sev_out shows the hex glyph of nibble i of the display value (digit 0 = bits [3:0]).
- led[9]=prog, led[10]=debug, led[11]=RX busy, led[12]=TX busy, led[13]=key unlocked (key==KEY_GOLDEN), led[15:14]=0.

## Timing
- Reset values: tx=1, clk_out=0, sev_out=7'h7F, an=8'hFF, led=0. rx_word, rx_count, holding register and scan index are all 0.
- an drives 8'hFE on the first cycle after reset release.
- rx_valid asserts 1 cycle after the stop-bit sample.
- Echo start bit: tx falls 2 cycles after rx_valid when TX is idle, or immediately after the current stop bit when TX is busy.
- clk_out toggles every clk edge after reset.
- An rx falling edge during STOP is not lost; it is seen on the next IDLE cycle.
- Reset mid-frame aborts both FSMs at once; tx returns to 1.
- prog changes take effect at the next rx_valid. A byte already queued still transmits.

## Configuration
- RV_KEY_LOCK_EN defined: scramble is computed from key as above, and led[13] reflects the key comparison.
- Undefined: scramble is forced to 0, key is ignored except on the debug display, and led[13] is tied to 1.

## Test plan
- Reset: hold Rst=0 for 10 ns, then release. tx=1, led=0, an=8'hFF during reset, an=8'hFE on the first cycle after release, clk_out toggling.
- Correct key, prog=0, receive 0xEF at 9000 ns/bit. led[7:0]=0xEF, and tx echoes 0xEF with a stop bit.
- Receive EF, BE, AD, DE with debug=0. rx_word=0xDEADBEEF; digit 7 shows "d" (sev_out=7'b0100001) when an=8'h7F; rx_count=4.
- Key bit 0 flipped, receive 0x55 (RV_KEY_LOCK_EN defined). Echo is 0x54; led[13]=0.
- Stop bit driven 0. No echo, led[7:0] unchanged, led[8]=1.
- prog=1, receive 0xA5. No tx activity; led[7:0]=0xA5, led[9]=1.
- debug=1, debug_input=2. The display shows 0x3cf3cf3c, which is key[95:64] for the KEY_GOLDEN value.

Source files
------------

// File: rtl/rv_uart_top_lite.sv
// rv_uart_top_lite: I/O shell with an 8N1 UART receiver, echo transmitter, seven-segment scanner and status LEDs.
// Define RV_KEY_LOCK_EN to scramble the echo with the logic-locking key; otherwise the key only feeds the display.
module rv_uart_top_lite #(
  parameter int          CLKS_PER_BIT = 900,
  parameter int          SCAN_CYCLES  = 1024,
  parameter logic [95:0] KEY_GOLDEN   = 96'h3cf3cf3cf3cf_30c30c_bae_3cf
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        rx,
  input  logic        prog,
  input  logic        debug,
  input  logic [4:0]  debug_input,
  input  logic [95:0] key,
  output logic        tx,
  output logic        clk_out,
  output logic [6:0]  sev_out,
  output logic [7:0]  an,
  output logic [15:0] led
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SCAN_M1  = SW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_ONE = SW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  function automatic logic [7:0] xor_bytes(input logic [95:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 12; i++) begin
      acc = acc ^ v[i*8 +: 8];
    end
    return acc;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic            clk_50M_q, clk_50M_d;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [31:0]     rx_word_q, rx_word_d;
  logic [7:0]      rx_count_q, rx_count_d;
  logic [7:0]      led_byte_q, led_byte_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            hold_take_s;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [2:0]      scan_idx_q, scan_idx_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      sev_q, sev_d;
  logic [15:0]     led_q, led_d;
  logic [7:0]      scramble_s;
  logic            key_ok_s;
  logic            echo_push_s;
  logic [7:0]      echo_byte_s;
  logic [31:0]     disp_s;
  logic            unused_s;

`ifdef RV_KEY_LOCK_EN
  assign scramble_s = xor_bytes(key ^ KEY_GOLDEN);
  assign key_ok_s   = (key == KEY_GOLDEN);
`else
  assign scramble_s = 8'h00;
  assign key_ok_s   = 1'b1;
`endif

  assign unused_s    = ^debug_input[4:2];
  assign echo_push_s = rx_valid_q & ~prog;
  assign echo_byte_s = rx_shift_q ^ scramble_s;

  // Input synchroniser and divided clock
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    clk_50M_d = ~clk_50M_q;
  end

  // Receiver: start detection with mid-bit glitch check, LSB-first data, mid-bit stop sample
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_bit_d   = 3'd0;
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Received-byte bookkeeping, taken in the rx_valid cycle
  always_comb begin
    rx_word_d  = rx_word_q;
    rx_count_d = rx_count_q;
    led_byte_d = led_byte_q;
    if (rx_valid_q) begin
      rx_word_d  = {rx_shift_q, rx_word_q[31:8]};
      rx_count_d = rx_count_q + 8'd1;
      led_byte_d = rx_shift_q;
    end else begin
      rx_word_d = rx_word_q;
    end
  end

  // Transmitter; a pending byte starts straight after the current stop bit
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_d         = 1'b1;
    hold_take_s  = 1'b0;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = CNT_ZERO;
        if (hold_valid_q) begin
          tx_state_d  = TX_START;
          tx_shift_d  = hold_q;
          hold_take_s = 1'b1;
          tx_d        = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = CNT_ZERO;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d   = CNT_ZERO;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = 3'd0;
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_d     = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d = CNT_ZERO;
          if (hold_valid_q) begin
            tx_state_d  = TX_START;
            tx_shift_d  = hold_q;
            hold_take_s = 1'b1;
            tx_d        = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CNT_ZERO;
        tx_d       = 1'b1;
      end
    endcase
    // A fresh echo overwrites the pending byte, even in the cycle it is consumed
    if (echo_push_s) begin
      hold_d       = echo_byte_s;
      hold_valid_d = 1'b1;
    end else if (hold_take_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Display source, digit scanner and LED image
  always_comb begin
    disp_s = rx_word_q;
    if (debug) begin
      case (debug_input[1:0])
        2'd0:    disp_s = key[31:0];
        2'd1:    disp_s = key[63:32];
        2'd2:    disp_s = key[95:64];
        2'd3:    disp_s = {24'h000000, rx_count_q};
        default: disp_s = rx_word_q;
      endcase
    end else begin
      disp_s = rx_word_q;
    end
    scan_cnt_d = scan_cnt_q + SCAN_ONE;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_M1) begin
      scan_cnt_d = {SW{1'b0}};
      scan_idx_d = scan_idx_q + 3'd1;
    end else begin
      scan_idx_d = scan_idx_q;
    end
    an_d  = ~(8'd1 << scan_idx_d);
    sev_d = hex_glyph(disp_s[{scan_idx_d, 2'b00} +: 4]);
    led_d = {2'b00, key_ok_s, (tx_state_q != TX_IDLE), (rx_state_q != RX_IDLE),
             debug, prog, frame_err_q, led_byte_q};
  end

  // State registers
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      clk_50M_q    <= 1'b0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= CNT_ZERO;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_word_q    <= 32'h0000_0000;
      rx_count_q   <= 8'h00;
      led_byte_q   <= 8'h00;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= CNT_ZERO;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      tx_q         <= 1'b1;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      scan_cnt_q   <= {SW{1'b0}};
      scan_idx_q   <= 3'd0;
      an_q         <= 8'hFF;
      sev_q        <= 7'h7F;
      led_q        <= 16'h0000;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      clk_50M_q    <= clk_50M_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      rx_word_q    <= rx_word_d;
      rx_count_q   <= rx_count_d;
      led_byte_q   <= led_byte_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      an_q         <= an_d;
      sev_q        <= sev_d;
      led_q        <= led_d;
    end
  end

  assign tx      = tx_q;
  assign clk_out = clk_50M_q;
  assign sev_out = sev_q;
  assign an      = an_q;
  assign led     = led_q;

endmodule

// File: tb/tb_rv_uart_top_lite.sv
// Bench for rv_uart_top_lite: drives UART frames, scoreboards echoed bytes and checks LEDs and the scanned display.
module tb_rv_uart_top_lite;
  localparam int CPB  = 100;
  localparam int SCAN = 16;
  localparam logic [95:0] GOLD = 96'h3cf3cf3cf3cf_30c30c_bae_3cf;
`ifdef RV_KEY_LOCK_EN
  localparam logic [7:0] FLIP_ECHO  = 8'h54;
  localparam logic       FLIP_LED13 = 1'b0;
`else
  localparam logic [7:0] FLIP_ECHO  = 8'h55;
  localparam logic       FLIP_LED13 = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        rx = 1'b1;
  logic        prog = 1'b0;
  logic        debug = 1'b0;
  logic [4:0]  debug_input = 5'd0;
  logic [95:0] key = GOLD;
  logic        tx, clk_out;
  logic [6:0]  sev_out;
  logic [7:0]  an;
  logic [15:0] led;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  rv_uart_top_lite #(.CLKS_PER_BIT(CPB), .SCAN_CYCLES(SCAN), .KEY_GOLDEN(GOLD)) dut (
    .clk(clk), .Rst(Rst), .rx(rx), .prog(prog), .debug(debug), .debug_input(debug_input),
    .key(key), .tx(tx), .clk_out(clk_out), .sev_out(sev_out), .an(an), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB / 4) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_digit(input int i, input logic [3:0] nib, input string tag);
    int n;
    logic [7:0] want;
    n = 0;
    want = ~(8'd1 << i);
    while (an !== want && n < 10 * SCAN) begin
      @(negedge clk);
      n++;
    end
    if (an !== want) check($sformatf("%s%0d_an_timeout", tag, i), {24'h0, an}, {24'h0, want});
    else check($sformatf("%s%0d", tag, i), {25'h0, sev_out}, {25'h0, glyph(nib)});
  endtask

  task automatic check_word(input logic [31:0] w, input string tag);
    for (int i = 0; i < 8; i++) check_digit(i, w[4*i +: 4], tag);
  endtask

  // Echo monitor: decodes every frame on tx and compares against the scoreboard
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (Rst === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", {31'h0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", {31'h0, tx}, 32'h1);
        if (exp_q.size() == 0) check("tx_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
        else check("echo", {24'h0, b}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin : main
    logic c0;
    int n;
    #1 Rst = 1'b0;
    #2;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_sev", {25'h0, sev_out}, 32'h7F);
    check("rst_clk_out", {31'h0, clk_out}, 32'h0);
    #8 Rst = 1'b1;
    @(negedge clk);
    check("an_first", {24'h0, an}, 32'hFE);
    c0 = clk_out;
    @(negedge clk);
    check("clk_out_toggle", {31'h0, clk_out}, {31'h0, ~c0});
    repeat (20) @(negedge clk);

    exp_q.push_back(8'hEF);
    send_byte(8'hEF, 1'b1);
    check("led_byte_ef", {24'h0, led[7:0]}, 32'hEF);
    check("led13_gold", {31'h0, led[13]}, 32'h1);
    foreach (exp_q[i]) begin end
    exp_q.push_back(8'hBE); send_byte(8'hBE, 1'b1);
    exp_q.push_back(8'hAD); send_byte(8'hAD, 1'b1);
    exp_q.push_back(8'hDE); send_byte(8'hDE, 1'b1);
    repeat (12 * CPB) @(negedge clk);
    check("led_byte_de", {24'h0, led[7:0]}, 32'hDE);
    check("led_ferr_clear", {31'h0, led[8]}, 32'h0);
    check("led_busy_idle", {30'h0, led[12:11]}, 32'h0);
    check_digit(7, 4'hD, "digit_d");
    check_word(32'hDEADBEEF, "rxword_dig");

    debug = 1'b1;
    debug_input = 5'b10111;
    repeat (2) @(negedge clk);
    check_digit(0, 4'h4, "count4_dig");
    check_digit(1, 4'h0, "count4_dig");
    debug = 1'b0;

    key[0] = ~key[0];
    exp_q.push_back(FLIP_ECHO);
    send_byte(8'h55, 1'b1);
    check("led13_flip", {31'h0, led[13]}, {31'h0, FLIP_LED13});
    repeat (12 * CPB) @(negedge clk);
    key = GOLD;

    send_byte(8'h33, 1'b0);
    check("led_byte_ferr", {24'h0, led[7:0]}, 32'h55);
    check("led_ferr", {31'h0, led[8]}, 32'h1);

    @(negedge clk) rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("led_byte_glitch", {24'h0, led[7:0]}, 32'h55);

    prog = 1'b1;
    send_byte(8'hA5, 1'b1);
    check("led_byte_prog", {24'h0, led[7:0]}, 32'hA5);
    check("led_prog", {31'h0, led[9]}, 32'h1);
    repeat (12 * CPB) @(negedge clk);

    debug = 1'b1;
    debug_input = 5'd2;
    repeat (3) @(negedge clk);
    check("led_debug", {31'h0, led[10]}, 32'h1);
    check_word(32'h3cf3cf3c, "key_hi_dig");
    debug_input = 5'd3;
    repeat (2) @(negedge clk);
    check_digit(0, 4'h6, "count6_dig");

    n = 0;
    while (exp_q.size() != 0 && n < 30 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("echo_queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
